// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter and its round-robin picker.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    // Index width that stays at least one bit wide for tiny parameter values.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot_enc(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_dec(input logic [MAX_REQ-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_priority_picker
    import tri_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W:0] pos;

    // Scan offsets from farthest to nearest so the nearest set request is the last write.
    always_comb begin
        winner = ptr;
        valid  = 1'b0;
        pos    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
            if (req[pos[IDX_W-1:0]]) begin
                winner = pos[IDX_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for one shared tri-state net, with hold limit and float gap.
//   state | meaning
//   IDLE  | bus floats, no request pending
//   GRANT | one owner drives the net, hold counter running
//   TURN  | bus floats for TURNAROUND cycles before the next owner
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         oe,
    output logic                     bus_busy,
    output logic [idx_w(N_REQ)-1:0]  owner_id,
    output logic                     timeout
);

    localparam int IDX_W  = idx_w(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURNAROUND + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt, owner_nxt, winner;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [TURN_W-1:0]  turn_cnt, turn_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic               timeout_nxt, win_valid, hold_limit, release_now;

    rr_priority_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    assign hold_limit  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now = !req[owner_id] || done[owner_id] || hold_limit;
    assign bus_busy    = |oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            oe       <= '0;
            owner_id <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            turn_cnt <= turn_nxt;
            gnt      <= gnt_nxt;
            oe       <= gnt_nxt;
            owner_id <= owner_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        turn_nxt  = turn_cnt;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = GRANT;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt = TURN;
                    turn_nxt  = TURN_W'(TURNAROUND - 1);
                    hold_nxt  = '0;
                    ptr_nxt   = (owner_id == IDX_W'(N_REQ - 1)) ? '0 : owner_id + 1'b1;
                end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt == '0) begin
                    state_nxt = win_valid ? GRANT : IDLE;
                    hold_nxt  = '0;
                end else begin
                    turn_nxt = turn_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new owner is only ever loaded from IDLE or TURN, so oe always passes through zero.
    always_comb begin
        gnt_nxt     = '0;
        owner_nxt   = owner_id;
        timeout_nxt = (state == GRANT) && hold_limit;
        if (state_nxt == GRANT) begin
            if (state == GRANT) begin
                gnt_nxt = gnt;
            end else begin
                gnt_nxt[winner] = 1'b1;
                owner_nxt       = winner;
            end
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed vector table and corner sequences on a 4-requester arbiter, plus a random
// run on an 8-requester arbiter with invariant and wait-bound monitoring.
module tb_tri_bus_arbiter;
    import tri_bus_pkg::*;

    localparam int BOUND8 = (8 - 1) * (16 + 2) + 1;

    logic       clk;
    logic       rst_n, rst8_n;
    logic [3:0] req, done, gnt, oe;
    logic [1:0] owner_id;
    logic       bus_busy, timeout;
    logic [7:0] req8, done8, gnt8, oe8;
    logic [2:0] owner8;
    logic       busy8, timeout8;

    int passed = 0;
    int total  = 0;
    int inv_viol = 0;
    int starve = 0;
    int grants8 = 0;

    tri_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt), .oe(oe),
        .bus_busy(bus_busy), .owner_id(owner_id), .timeout(timeout)
    );

    tri_bus_arbiter #(.N_REQ(8), .MAX_HOLD(16), .TURNAROUND(2)) dut8 (
        .clk(clk), .rst_n(rst8_n), .req(req8), .done(done8), .gnt(gnt8), .oe(oe8),
        .bus_busy(busy8), .owner_id(owner8), .timeout(timeout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       to;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string nm, input logic [3:0] g, input logic [1:0] o, input logic t);
        check(nm, {20'd0, gnt, oe, owner_id, timeout, bus_busy}, {20'd0, g, g, o, t, |g});
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        done  = '0;
        #12;
        expect4("reset_state", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] prev_oe;
    logic [7:0] prev_oe8;
    initial begin
        prev_oe  = '0;
        prev_oe8 = '0;
    end

    always @(negedge clk) begin
        if (oe !== gnt || !$onehot0(oe) || bus_busy !== (|oe) ||
            (prev_oe != 0 && oe != 0 && oe != prev_oe)) begin
            inv_viol++;
            $display("FAIL invariant_n4: oe=%b gnt=%b busy=%b prev_oe=%b", oe, gnt, bus_busy, prev_oe);
        end
        if (oe8 !== gnt8 || !$onehot0(oe8) || busy8 !== (|oe8) ||
            (prev_oe8 != 0 && oe8 != 0 && oe8 != prev_oe8)) begin
            inv_viol++;
            $display("FAIL invariant_n8: oe=%b gnt=%b busy=%b prev_oe=%b", oe8, gnt8, busy8, prev_oe8);
        end
        prev_oe  = oe;
        prev_oe8 = oe8;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_g;
        logic [15:0] oh;
        int          wait8 [8];
        logic [7:0]  prev_g8;
        int          r;

        rst_n  = 1'b0;
        rst8_n = 1'b0;
        req    = '0;
        done   = '0;
        req8   = '0;
        done8  = '0;

        //            req      done     gnt      owner  to
        vecs[0]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0};
        vecs[1]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        vecs[7]  = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0};
        vecs[8]  = '{4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0000, 2'd3, 1'b0};
        vecs[10] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0};
        vecs[11] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b0};
        vecs[12] = '{4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

        do_reset(4'b0101);
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req, vecs[i].done);
            expect4($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].to);
        end

        // All requesting: 16-cycle grants rotating 0,1,2,3,0 with a timeout float cycle between.
        do_reset(4'b1111);
        for (int g = 0; g < 5; g++) begin
            oh    = onehot_enc(MAX_IDX_W'(g % 4));
            exp_g = oh[3:0];
            for (int c = 0; c < 16; c++) begin
                step(4'b1111, 4'b0000);
                expect4($sformatf("rot%0d_c%0d", g, c), exp_g, 2'(g % 4), 1'b0);
            end
            step(4'b1111, (g == 4) ? 4'b0001 : 4'b0000);
            expect4($sformatf("rot%0d_timeout", g), 4'b0000, 2'(g % 4), 1'b1);
        end

        // Owner 2 releases with done after three grant cycles.
        do_reset(4'b0000);
        step(4'b0100, 4'b0000); expect4("done_g1", 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 4'b0000); expect4("done_g2", 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 4'b0000); expect4("done_g3", 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 4'b0100); expect4("done_rel", 4'b0000, 2'd2, 1'b0);
        step(4'b0000, 4'b0000); expect4("done_turn", 4'b0000, 2'd2, 1'b0);
        step(4'b0000, 4'b0000); expect4("done_idle", 4'b0000, 2'd2, 1'b0);

        // Asynchronous reset while requester 1 owns the bus, pointer returns to 0.
        do_reset(4'b0000);
        step(4'b0001, 4'b0000); expect4("ar_g0", 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000); expect4("ar_rel", 4'b0000, 2'd0, 1'b0);
        step(4'b0010, 4'b0000); expect4("ar_g1", 4'b0010, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect4("ar_async", 4'b0000, 2'd0, 1'b0);
        req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0011, 4'b0000); expect4("ar_ptr0", 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000);

        // Random traffic on the 8-requester instance.
        prev_g8 = '0;
        for (int i = 0; i < 8; i++) wait8[i] = 0;
        @(negedge clk);
        rst8_n = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (gnt8[i]) begin
                    if (!prev_g8[i]) grants8++;
                    wait8[i] = 0;
                end else if (req8[i]) begin
                    if (prev_g8[i]) begin
                        req8[i] = 1'b0;
                    end else begin
                        wait8[i]++;
                        if (wait8[i] > BOUND8) begin
                            starve++;
                            $display("FAIL wait_bound: requester %0d waited %0d limit %0d", i, wait8[i], BOUND8);
                            wait8[i] = 0;
                        end
                    end
                end
            end
            done8 = '0;
            for (int i = 0; i < 8; i++) begin
                if (!req8[i] && !gnt8[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req8[i]  = 1'b1;
                        wait8[i] = 0;
                    end
                end else if (req8[i] && gnt8[i]) begin
                    r = int'($urandom_range(0, 19));
                    if (r == 0) req8[i] = 1'b0;
                    else if (r == 1) done8[i] = 1'b1;
                end else if (!gnt8[i] && $urandom_range(0, 9) == 0) begin
                    done8[i] = 1'b1;
                end
            end
            prev_g8 = gnt8;
        end

        check("invariant_violations", 32'(inv_viol), 32'd0);
        check("wait_bound_violations", 32'(starve), 32'd0);
        check("random_grants_seen", {31'd0, grants8 > 100}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
